// File: rtl/prefetch_unit.sv
// Instruction prefetcher: fetches 16-bit words at CS:IP into a byte queue drained by the decoder.
// A CS:IP load flushes the queue; an in-flight bus access is completed and its data discarded.
module prefetch_unit #(
  parameter int unsigned FIFO_DEPTH = 6
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cs,
  input  logic [15:0] new_ip,
  input  logic        load_new_ip,
  input  logic        fifo_rd_en,
  output logic [7:0]  fifo_rd_data,
  output logic        fifo_empty,
  output logic [18:0] mem_address,
  output logic        mem_access,
  input  logic        mem_ack,
  input  logic [15:0] mem_data
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, FETCH, ABORT} state_t;

  state_t            state, state_next;
  logic [15:0]       fetch_ip;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [7:0]        store [FIFO_DEPTH];

  logic              pop, push, issue, room;
  logic [CNT_W-1:0]  count_after_pop, free, n_push;
  logic [18:0]       word_addr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Physical address >> 1: cs*16 is even, so the word address is cs*8 + ip/2 (mod 2^19).
  assign word_addr = {cs, 3'b000} + {4'b0000, fetch_ip[15:1]};

  assign pop             = fifo_rd_en && (count != '0) && !load_new_ip;
  assign count_after_pop = count - CNT_W'(pop);
  assign free            = CNT_W'(FIFO_DEPTH) - count_after_pop;
  assign room            = fetch_ip[0] ? (free >= CNT_W'(1)) : (free >= CNT_W'(2));
  assign issue           = (state == IDLE) && !load_new_ip && room;
  assign push            = (state == FETCH) && mem_ack && !load_new_ip;
  assign n_push          = push ? (fetch_ip[0] ? CNT_W'(1) : CNT_W'(2)) : '0;

  assign fifo_rd_data = store[rd_ptr];
  assign fifo_empty   = (count == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // A redirect without an ack in FETCH must still wait out the bus cycle in ABORT.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (issue) state_next = FETCH;
      FETCH:   if (mem_ack) state_next = IDLE;
               else if (load_new_ip) state_next = ABORT;
      ABORT:   if (mem_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_access  <= 1'b0;
      mem_address <= '0;
      fetch_ip    <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) store[i] <= '0;
    end else begin
      mem_access <= (state_next != IDLE);
      if (issue) mem_address <= word_addr;
      if (load_new_ip) begin
        fetch_ip <= new_ip;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (push) begin
          if (fetch_ip[0]) begin
            store[wr_ptr] <= mem_data[15:8];
            wr_ptr        <= ptr_inc(wr_ptr);
            fetch_ip      <= fetch_ip + 16'd1;
          end else begin
            store[wr_ptr]          <= mem_data[7:0];
            store[ptr_inc(wr_ptr)] <= mem_data[15:8];
            wr_ptr                 <= ptr_inc(ptr_inc(wr_ptr));
            fetch_ip               <= fetch_ip + 16'd2;
          end
        end
        if (pop) rd_ptr <= ptr_inc(rd_ptr);
        count <= count_after_pop + n_push;
      end
    end
  end

endmodule

// File: tb/tb_prefetch_unit.sv
// Directed bench for prefetch_unit: fetch/queue order, odd IPs, fill limit, redirects, wrap, reset.
module tb_prefetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] cs, new_ip, mem_data;
  logic        load_new_ip, fifo_rd_en, mem_ack;
  logic [7:0]  fifo_rd_data;
  logic        fifo_empty, mem_access;
  logic [18:0] mem_address;

  int errors = 0;
  int checks = 0;

  prefetch_unit #(.FIFO_DEPTH(6)) dut (
    .clk(clk), .reset_n(reset_n), .cs(cs), .new_ip(new_ip), .load_new_ip(load_new_ip),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
    .mem_address(mem_address), .mem_access(mem_access), .mem_ack(mem_ack), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; load_new_ip = 1'b0; fifo_rd_en = 1'b0; mem_ack = 1'b0;
    cs = '0; new_ip = '0; mem_data = '0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic redirect(input logic [15:0] c, input logic [15:0] ip);
    cs = c; new_ip = ip; load_new_ip = 1'b1;
    tick();
    load_new_ip = 1'b0;
  endtask

  task automatic ack(input logic [15:0] d);
    mem_ack = 1'b1; mem_data = d;
    tick();
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; load_new_ip = 1'b0; fifo_rd_en = 1'b0; mem_ack = 1'b0;
    cs = 16'h1234; new_ip = '0; mem_data = '0;
    tick(); tick();
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%0b exp=1", fifo_empty); end
    checks++; if (mem_access !== 1'b0) begin errors++; $display("FAIL reset_access got=%0b exp=0", mem_access); end
    checks++; if (mem_address !== 19'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", mem_address); end
    checks++; if (fifo_rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got=%h exp=00", fifo_rd_data); end
  endtask

  task automatic test_basic();
    do_reset();
    redirect(16'h1000, 16'h0100);
    checks++; if (mem_access !== 1'b0) begin errors++; $display("FAIL basic_no_access_yet got=%0b exp=0", mem_access); end
    tick();
    checks++; if (mem_access !== 1'b1 || mem_address !== 19'h08080) begin
      errors++; $display("FAIL basic_req got=%0b/%h exp=1/08080", mem_access, mem_address); end
    ack(16'hBBAA);
    checks++; if (mem_access !== 1'b0 || fifo_empty !== 1'b0 || fifo_rd_data !== 8'hAA) begin
      errors++; $display("FAIL basic_after_ack got=%0b/%0b/%h exp=0/0/aa", mem_access, fifo_empty, fifo_rd_data); end
    fifo_rd_en = 1'b1;
    tick();
    checks++; if (fifo_rd_data !== 8'hBB) begin errors++; $display("FAIL basic_second_byte got=%h exp=bb", fifo_rd_data); end
    checks++; if (mem_access !== 1'b1 || mem_address !== 19'h08081) begin
      errors++; $display("FAIL basic_next_req got=%0b/%h exp=1/08081", mem_access, mem_address); end
    tick();
    fifo_rd_en = 1'b0;
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL basic_drained got=%0b exp=1", fifo_empty); end
  endtask

  task automatic test_odd_ip();
    do_reset();
    redirect(16'h0000, 16'h0003);
    tick();
    checks++; if (mem_access !== 1'b1 || mem_address !== 19'h00001) begin
      errors++; $display("FAIL odd_req got=%0b/%h exp=1/00001", mem_access, mem_address); end
    ack(16'h2211);
    checks++; if (fifo_rd_data !== 8'h22 || fifo_empty !== 1'b0) begin
      errors++; $display("FAIL odd_byte got=%h/%0b exp=22/0", fifo_rd_data, fifo_empty); end
    fifo_rd_en = 1'b1;
    tick();
    fifo_rd_en = 1'b0;
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL odd_single_byte got=%0b exp=1", fifo_empty); end
    checks++; if (mem_access !== 1'b1 || mem_address !== 19'h00002) begin
      errors++; $display("FAIL odd_next_req got=%0b/%h exp=1/00002", mem_access, mem_address); end
  endtask

  task automatic test_fill();
    int reqs = 0;
    do_reset();
    redirect(16'h0000, 16'h0000);
    for (int i = 0; i < 12; i++) begin
      if (mem_access) begin
        mem_ack = 1'b1; mem_data = {8'(2 * reqs + 1), 8'(2 * reqs)}; reqs++;
      end else mem_ack = 1'b0;
      tick();
    end
    mem_ack = 1'b0;
    checks++; if (reqs !== 3) begin errors++; $display("FAIL fill_requests got=%0d exp=3", reqs); end
    checks++; if (mem_access !== 1'b0 || fifo_rd_data !== 8'h00) begin
      errors++; $display("FAIL fill_full got=%0b/%h exp=0/00", mem_access, fifo_rd_data); end
    fifo_rd_en = 1'b1; tick(); fifo_rd_en = 1'b0;
    tick();
    checks++; if (mem_access !== 1'b0 || fifo_rd_data !== 8'h01) begin
      errors++; $display("FAIL fill_one_pop got=%0b/%h exp=0/01", mem_access, fifo_rd_data); end
    fifo_rd_en = 1'b1; tick(); fifo_rd_en = 1'b0;
    checks++; if (mem_access !== 1'b1 || mem_address !== 19'h00003 || fifo_rd_data !== 8'h02) begin
      errors++; $display("FAIL fill_two_pops got=%0b/%h/%h exp=1/00003/02", mem_access, mem_address, fifo_rd_data); end
  endtask

  task automatic test_redirect_fetch();
    do_reset();
    redirect(16'h2000, 16'h0010);
    tick();
    checks++; if (mem_access !== 1'b1 || mem_address !== 19'h10008) begin
      errors++; $display("FAIL redir_req got=%0b/%h exp=1/10008", mem_access, mem_address); end
    redirect(16'h3000, 16'h0040);
    tick(); tick();
    checks++; if (mem_access !== 1'b1 || mem_address !== 19'h10008) begin
      errors++; $display("FAIL redir_hold got=%0b/%h exp=1/10008", mem_access, mem_address); end
    ack(16'hDEAD);
    checks++; if (mem_access !== 1'b0 || fifo_empty !== 1'b1) begin
      errors++; $display("FAIL redir_discard got=%0b/%0b exp=0/1", mem_access, fifo_empty); end
    tick();
    checks++; if (mem_access !== 1'b1 || mem_address !== 19'h18020 || fifo_empty !== 1'b1) begin
      errors++; $display("FAIL redir_new_req got=%0b/%h/%0b exp=1/18020/1", mem_access, mem_address, fifo_empty); end
  endtask

  task automatic test_wrap();
    do_reset();
    redirect(16'hFFFF, 16'h0010);
    tick();
    checks++; if (mem_access !== 1'b1 || mem_address !== 19'h00000) begin
      errors++; $display("FAIL wrap_phys got=%0b/%h exp=1/00000", mem_access, mem_address); end
    do_reset();
    redirect(16'h0000, 16'hFFFF);
    tick();
    checks++; if (mem_address !== 19'h07FFF) begin errors++; $display("FAIL wrap_ip_req got=%h exp=07fff", mem_address); end
    ack(16'hAB12);
    checks++; if (fifo_rd_data !== 8'hAB) begin errors++; $display("FAIL wrap_ip_byte got=%h exp=ab", fifo_rd_data); end
    tick();
    checks++; if (mem_access !== 1'b1 || mem_address !== 19'h00000) begin
      errors++; $display("FAIL wrap_ip_next got=%0b/%h exp=1/00000", mem_access, mem_address); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    redirect(16'h0000, 16'h0020);
    tick();
    ack(16'h5544);
    tick();
    checks++; if (mem_access !== 1'b1 || mem_address !== 19'h00011 || fifo_rd_data !== 8'h44) begin
      errors++; $display("FAIL simul_setup got=%0b/%h/%h exp=1/00011/44", mem_access, mem_address, fifo_rd_data); end
    cs = 16'h0000; new_ip = 16'h0100; load_new_ip = 1'b1; fifo_rd_en = 1'b1;
    mem_ack = 1'b1; mem_data = 16'h7766;
    tick();
    load_new_ip = 1'b0; fifo_rd_en = 1'b0; mem_ack = 1'b0;
    checks++; if (fifo_empty !== 1'b1 || mem_access !== 1'b0) begin
      errors++; $display("FAIL simul_flush got=%0b/%0b exp=1/0", fifo_empty, mem_access); end
    tick();
    checks++; if (mem_access !== 1'b1 || mem_address !== 19'h00080) begin
      errors++; $display("FAIL simul_new_ip got=%0b/%h exp=1/00080", mem_access, mem_address); end
    ack(16'h9988);
    checks++; if (fifo_rd_data !== 8'h88) begin errors++; $display("FAIL simul_new_data got=%h exp=88", fifo_rd_data); end
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    redirect(16'h0000, 16'h0000);
    tick();
    ack(16'h3322);
    tick();
    checks++; if (mem_access !== 1'b1 || fifo_empty !== 1'b0) begin
      errors++; $display("FAIL rstmid_setup got=%0b/%0b exp=1/0", mem_access, fifo_empty); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (mem_access !== 1'b0 || fifo_empty !== 1'b1 || mem_address !== 19'h0) begin
      errors++; $display("FAIL rstmid_async got=%0b/%0b/%h exp=0/1/0", mem_access, fifo_empty, mem_address); end
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_odd_ip();
    test_fill();
    test_redirect_fetch();
    test_wrap();
    test_simultaneous();
    test_reset_mid_fetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prefetch_unit.md
Name: prefetch_unit

Overview:
- Instruction prefetcher that sits directly downstream of the CS:IP synchroniser.
- Takes the atomically delivered CS and new IP, fetches 16-bit instruction words from memory, and queues the bytes in a small FIFO.
- The FIFO is read one byte at a time by the instruction decoder.
- A CS:IP load flushes the queue and redirects fetching. A memory access already in flight completes on the bus, and its data is discarded.

Parameters:
- FIFO_DEPTH, 6, byte capacity of the prefetch queue; must be >= 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cs  in  16  current code segment; sampled when a fetch is issued.
- new_ip  in  16  redirect IP from the CS:IP synchroniser.
- load_new_ip  in  1  one-cycle redirect strobe (synchroniser update output).
- fifo_rd_en  in  1  decoder pops one byte.
- fifo_rd_data  out  8  head byte of the queue; combinational from the head entry.
- fifo_empty  out  1  queue holds no bytes.
- mem_address  out  19  word address, physical[19:1].
- mem_access  out  1  memory request.
- mem_ack  in  1  request complete; mem_data valid in this cycle.
- mem_data  in  16  read data, little-endian.

Behaviour:
- Reset (reset_n low, asynchronous):
  - fetch_ip=0, count=0, state=IDLE.
  - fifo_empty=1, mem_access=0, mem_address=0, fifo_rd_data=0.
  - Reset mid-access abandons the access immediately; no handshake completion is required.
- Physical address:
  - phys = ({cs,4'b0} + {4'b0,fetch_ip}) mod 2^20.
  - mem_address = phys[19:1].
- States:
  - IDLE:
    - Issue a fetch when not redirecting and free >= 2 (fetch_ip even) or free >= 1 (fetch_ip odd).
    - free = FIFO_DEPTH - count, evaluated after this cycle's pop.
    - On issue: mem_access=1 from the next cycle; go to FETCH.
  - FETCH:
    - mem_access and mem_address are held stable until mem_ack.
    - On mem_ack with fetch_ip even: push mem_data[7:0] then mem_data[15:8] (low byte first); fetch_ip += 2.
    - On mem_ack with fetch_ip odd: push mem_data[15:8] only; fetch_ip += 1.
    - After mem_ack: mem_access=0 the next cycle; return to IDLE.
    - At least one idle bus cycle separates requests.
  - ABORT:
    - Entered when load_new_ip occurs while in FETCH without mem_ack.
    - mem_access stays asserted with the old address until mem_ack.
    - Data on that ack is discarded; then go to IDLE.
- fetch_ip arithmetic is 16-bit and wraps 0xFFFF -> 0x0000. An odd 0xFFFF fetch pushes one byte and yields fetch_ip=0x0000.
- Redirect (load_new_ip=1):
  - The same edge clears the queue (count=0, pointers reset) and sets fetch_ip=new_ip.
  - fifo_rd_en in the same cycle is ignored.
  - If mem_ack coincides with load_new_ip, the ack data is dropped and the next state is IDLE.
  - From IDLE, the new request appears at the earliest one cycle after the redirect cycle.
  - A redirect while in ABORT just updates fetch_ip; state stays ABORT.
- Queue:
  - Push and pop in the same cycle are both honoured; count is updated by pushes minus pops.
  - Pop when empty is ignored.
  - Pushes never exceed capacity: free space is guaranteed at issue time, and no pop can reduce it.
  - count width is clog2(FIFO_DEPTH+1); pointers wrap modulo FIFO_DEPTH.
- fifo_empty = (count==0). It is combinational from registered state.

Test Plan:
- Reset then cs=0x1000, load_new_ip with new_ip=0x0100 -> mem_access rises with mem_address=0x10100>>1=0x8080. Ack with mem_data=0xBBAA -> bytes AA then BB popped; next request goes to 0x8081.
- Odd IP: cs=0, new_ip=0x0003, ack mem_data=0x2211 -> only 0x22 queued; next fetch_ip=0x0004, mem_address=0x0002.
- Fill without pops, FIFO_DEPTH=6, even IP -> exactly 3 requests then mem_access stays 0. A single pop keeps it idle (free=1, IP even). A second pop issues the next fetch.
- Redirect during FETCH (ack delayed 3 cycles) -> mem_access and the old address are held until ack, the acked data never appears, fifo_empty=1. The next request uses the new CS:IP.
- Wrap: cs=0xFFFF, new_ip=0x0010 -> phys 0x00000, mem_address=0. Separately, cs=0, new_ip=0xFFFF -> one byte pushed, next mem_address=0x0000.
- Simultaneous: load_new_ip coincident with mem_ack and fifo_rd_en on a non-empty queue -> queue empty after the edge, fetch_ip=new_ip, no ack bytes pushed.
- Reset asserted mid-FETCH -> mem_access drops asynchronously, fifo_empty=1.
